cipher_core: RTL and testbench



---
 rtl/cipher_pkg.sv | 31 +++
 rtl/cipher_shift.sv | 34 +++
 rtl/cipher_core.sv | 142 ++++++++++++++
 tb/tb_cipher_core.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/cipher_pkg.sv
// Shared encodings, ASCII constants and helpers for the keyboard Vigenere cipher.
// Both the core FSM and the letter-shift datapath use these.
package cipher_pkg;

   localparam int KEY_IDX_W = 2;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_LOAD_KEY = 3'd1,
      ST_ENCRYPT  = 3'd2,
      ST_DECRYPT  = 3'd3
   } state_t;

   localparam logic [7:0] ASCII_UPPER_A = 8'h41;
   localparam logic [7:0] ASCII_UPPER_Z = 8'h5A;
   localparam logic [7:0] ASCII_LOWER_A = 8'h61;
   localparam logic [7:0] ASCII_LOWER_Z = 8'h7A;
   localparam logic [7:0] CASE_MASK     = 8'hDF;
   localparam logic [5:0] ALPHABET_LEN  = 6'd26;

   function automatic logic is_letter(input logic [7:0] c);
      return ((c >= ASCII_UPPER_A) && (c <= ASCII_UPPER_Z)) ||
             ((c >= ASCII_LOWER_A) && (c <= ASCII_LOWER_Z));
   endfunction

   // Only meaningful for letters: clearing bit 5 maps 'a'..'z' onto 'A'..'Z'.
   function automatic logic [7:0] to_upper(input logic [7:0] c);
      return c & CASE_MASK;
   endfunction

endpackage

// File: rtl/cipher_shift.sv
// Combinational Caesar shift of one ASCII character, case preserved.
// Non-letters pass through unchanged and deassert is_letter.
module cipher_shift (
   input  logic [7:0] in_char,
   input  logic [4:0] shift,
   input  logic       decrypt,
   output logic [7:0] out_char,
   output logic       is_letter
);
   import cipher_pkg::*;

   logic       lower;
   logic [7:0] base;
   logic [4:0] offset;
   logic [5:0] sum;
   logic [5:0] wrapped;

   always_comb begin
      is_letter = cipher_pkg::is_letter(in_char);
      lower     = (in_char >= ASCII_LOWER_A);
      base      = lower ? ASCII_LOWER_A : ASCII_UPPER_A;
      offset    = 5'(in_char - base);
      // Both operands are below 26, so a single +/-26 brings the result back into range.
      if (decrypt) begin
         sum     = {1'b0, offset} - {1'b0, shift};
         wrapped = sum[5] ? sum + ALPHABET_LEN : sum;
      end else begin
         sum     = {1'b0, offset} + {1'b0, shift};
         wrapped = (sum >= ALPHABET_LEN) ? sum - ALPHABET_LEN : sum;
      end
      out_char = is_letter ? base + {2'b00, wrapped} : in_char;
   end

endmodule

// File: rtl/cipher_core.sv
// Keyboard cipher control: edge detection, key register file, FSM and display strobe.
// Collects a 1..KEY_SLOTS letter key, then encrypts/decrypts each keystroke.
module cipher_core
   import cipher_pkg::*;
#(
   parameter int KEY_SLOTS = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 enter,
   input  logic                 kb_toggle,
   input  logic [7:0]           kb_char,
   output logic [2:0]           state,
   output logic [7:0]           vga_char,
   output logic                 vga_strobe,
   output logic [KEY_IDX_W-1:0] cipher_idx
);

   localparam int                   LEN_W   = 3;
   localparam int                   MAX_KEY = 4;
   localparam logic [LEN_W-1:0]     SLOTS_L = LEN_W'(KEY_SLOTS);
   localparam logic [KEY_IDX_W-1:0] MAX_IDX = KEY_IDX_W'(KEY_SLOTS - 1);

   state_t               state_reg;
   logic                 enter_q_reg;
   logic                 tog_q_reg;
   logic [LEN_W-1:0]     key_len_reg;
   logic [KEY_IDX_W-1:0] idx_reg;
   logic [7:0]           vga_char_reg;
   logic                 vga_strobe_reg;

   logic                 ent_ev;
   logic                 key_ev;
   logic                 key_wr_en;
   logic [7:0]           key_slot [MAX_KEY];
   logic [4:0]           key_shift;
   logic [7:0]           shifted_char;
   logic                 char_is_letter;
   logic [LEN_W-1:0]     idx_inc;
   logic [KEY_IDX_W-1:0] idx_next;

   assign ent_ev = enter & ~enter_q_reg;
   assign key_ev = kb_toggle ^ tog_q_reg;

   assign key_wr_en = (state_reg == ST_LOAD_KEY) && !ent_ev && key_ev &&
                      char_is_letter && (key_len_reg < SLOTS_L);

   // Slots beyond KEY_SLOTS read back as 'A' so a 4-entry mux works for any legal size.
   for (genvar gi = 0; gi < MAX_KEY; gi++) begin : g_key
      if (gi < KEY_SLOTS) begin : g_slot
         logic [7:0] slot_reg;
         always_ff @(posedge clk) begin
            if (reset) begin
               slot_reg <= ASCII_UPPER_A;
            end else if (key_wr_en && (key_len_reg == LEN_W'(gi))) begin
               slot_reg <= to_upper(kb_char);
            end
         end
         assign key_slot[gi] = slot_reg;
      end else begin : g_pad
         assign key_slot[gi] = ASCII_UPPER_A;
      end
   end

   assign key_shift = 5'(key_slot[idx_reg] - ASCII_UPPER_A);

   cipher_shift u_shift (
      .in_char   (kb_char),
      .shift     (key_shift),
      .decrypt   (state_reg == ST_DECRYPT),
      .out_char  (shifted_char),
      .is_letter (char_is_letter)
   );

   // idx walks 0..key_len-1 and wraps; key_len is at least 1 whenever this is used.
   assign idx_inc  = {1'b0, idx_reg} + LEN_W'(1);
   assign idx_next = (idx_inc >= key_len_reg) ? '0 : idx_inc[KEY_IDX_W-1:0];

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg      <= ST_IDLE;
         enter_q_reg    <= enter;
         tog_q_reg      <= kb_toggle;
         key_len_reg    <= '0;
         idx_reg        <= '0;
         vga_char_reg   <= 8'h00;
         vga_strobe_reg <= 1'b0;
      end else begin
         enter_q_reg    <= enter;
         tog_q_reg      <= kb_toggle;
         vga_strobe_reg <= 1'b0;
         case (state_reg)
            ST_IDLE: begin
               if (ent_ev) begin
                  state_reg   <= ST_LOAD_KEY;
                  key_len_reg <= '0;
               end
            end
            ST_LOAD_KEY: begin
               if (ent_ev) begin
                  if (key_len_reg != '0) begin
                     state_reg <= ST_ENCRYPT;
                     idx_reg   <= '0;
                  end
               end else if (key_wr_en) begin
                  key_len_reg    <= key_len_reg + LEN_W'(1);
                  vga_char_reg   <= to_upper(kb_char);
                  vga_strobe_reg <= 1'b1;
               end
            end
            ST_ENCRYPT, ST_DECRYPT: begin
               if (ent_ev) begin
                  state_reg <= (state_reg == ST_ENCRYPT) ? ST_DECRYPT : ST_IDLE;
                  idx_reg   <= '0;
               end else if (key_ev) begin
                  vga_char_reg   <= shifted_char;
                  vga_strobe_reg <= 1'b1;
                  if (char_is_letter) begin
                     idx_reg <= idx_next;
                  end
               end
            end
            default: state_reg <= ST_IDLE;
         endcase
      end
   end

   always_comb begin
      cipher_idx = '0;
      case (state_reg)
         ST_LOAD_KEY: cipher_idx = (key_len_reg >= LEN_W'(MAX_IDX)) ? MAX_IDX
                                                                  : key_len_reg[KEY_IDX_W-1:0];
         ST_ENCRYPT, ST_DECRYPT: cipher_idx = idx_reg;
         default: cipher_idx = '0;
      endcase
   end

   assign state      = state_reg;
   assign vga_char   = vga_char_reg;
   assign vga_strobe = vga_strobe_reg;

endmodule

// File: tb/tb_cipher_core.sv
// Scoreboard bench for cipher_core: directed scenarios then random keystrokes,
// checked against a character-level Vigenere model.
module tb_cipher_core;

   localparam int KS = 4;

   logic       clk = 1'b0;
   logic       reset;
   logic       enter;
   logic       kb_toggle;
   logic [7:0] kb_char;
   logic [2:0] state;
   logic [7:0] vga_char;
   logic       vga_strobe;
   logic [1:0] cipher_idx;

   cipher_core #(.KEY_SLOTS(KS)) dut (
      .clk        (clk),
      .reset      (reset),
      .enter      (enter),
      .kb_toggle  (kb_toggle),
      .kb_char    (kb_char),
      .state      (state),
      .vga_char   (vga_char),
      .vga_strobe (vga_strobe),
      .cipher_idx (cipher_idx)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Model state: 0 idle, 1 load key, 2 encrypt, 3 decrypt
   int   m_state;
   int   m_len;
   int   m_idx;
   int   m_key [KS];
   logic [7:0] exp_q [$];

   task automatic chk(input string name, input logic [31:0] actual, input logic [31:0] expected);
      n_checks++;
      if (actual !== expected) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
      end
   endtask

   always @(negedge clk) begin
      if (vga_strobe) begin
         n_checks++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL strobe_unexpected: got vga_char=%h, expected no strobe at %0t", vga_char, $time);
         end else begin
            logic [7:0] e;
            e = exp_q.pop_front();
            if (vga_char !== e) begin
               n_fail++;
               $display("FAIL vga_char: got %h, expected %h at %0t", vga_char, e, $time);
            end else begin
               $display("strobe char=%h ok", vga_char);
            end
         end
      end
   end

   function automatic bit is_alpha(input int c);
      return (c >= 65 && c <= 90) || (c >= 97 && c <= 122);
   endfunction

   function automatic int exp_idx();
      if (m_state == 1) return (m_len < KS - 1) ? m_len : KS - 1;
      if (m_state == 2 || m_state == 3) return m_idx;
      return 0;
   endfunction

   task automatic model_reset();
      m_state = 0; m_len = 0; m_idx = 0;
      for (int i = 0; i < KS; i++) m_key[i] = 65;
   endtask

   task automatic model_key(input int c);
      int base, sh, res;
      if (m_state == 1) begin
         if (is_alpha(c) && m_len < KS) begin
            m_key[m_len] = (c >= 97) ? c - 32 : c;
            exp_q.push_back(8'(m_key[m_len]));
            m_len++;
         end
      end else if (m_state == 2 || m_state == 3) begin
         if (is_alpha(c)) begin
            base = (c >= 97) ? 97 : 65;
            sh   = m_key[m_idx] - 65;
            res  = (m_state == 2) ? (c - base + sh) % 26 : (c - base - sh + 26) % 26;
            exp_q.push_back(8'(base + res));
            m_idx = (m_idx + 1) % m_len;
         end else begin
            exp_q.push_back(8'(c));
         end
      end
   endtask

   task automatic model_enter();
      case (m_state)
         0: begin m_state = 1; m_len = 0; end
         1: if (m_len > 0) begin m_state = 2; m_idx = 0; end
         2: begin m_state = 3; m_idx = 0; end
         default: m_state = 0;
      endcase
   endtask

   task automatic post_check(input string what);
      chk({what, "_strobe_pending"}, exp_q.size(), 0);
      chk({what, "_state"}, state, m_state);
      chk({what, "_cipher_idx"}, cipher_idx, exp_idx());
      $display("%s: state=%0d idx=%0d", what, state, cipher_idx);
   endtask

   // All action tasks start and end at negedge+1.
   task automatic do_key(input logic [7:0] c);
      model_key(c);
      kb_char   = c;
      kb_toggle = ~kb_toggle;
      @(posedge clk); @(negedge clk); #1;
      post_check("key");
   endtask

   task automatic do_enter();
      model_enter();
      enter = 1'b1;
      @(posedge clk); @(negedge clk); #1;
      enter = 1'b0;
      @(posedge clk); @(negedge clk); #1;
      post_check("enter");
   endtask

   task automatic do_both(input logic [7:0] c);
      model_enter();
      kb_char   = c;
      kb_toggle = ~kb_toggle;
      enter     = 1'b1;
      @(posedge clk); @(negedge clk); #1;
      enter = 1'b0;
      @(posedge clk); @(negedge clk); #1;
      post_check("enter_key");
   endtask

   task automatic do_reset_key(input logic [7:0] c);
      kb_char   = c;
      kb_toggle = ~kb_toggle;
      reset     = 1'b1;
      @(posedge clk); @(negedge clk); #1;
      reset = 1'b0;
      model_reset();
      chk("reset_vga_char", vga_char, 0);
      @(posedge clk); @(negedge clk); #1;
      post_check("reset");
   endtask

   function automatic logic [7:0] rand_char();
      if ($urandom_range(0, 9) < 7)
         return 8'($urandom_range(0, 25) + (($urandom_range(0, 1) == 1) ? 97 : 65));
      return 8'($urandom_range(32, 126));
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not finish, expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      int r;
      reset = 1'b1; enter = 1'b0; kb_toggle = 1'b1; kb_char = 8'h00;
      model_reset();
      repeat (3) @(negedge clk);
      #1 reset = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      chk("reset_state", state, 0);
      chk("reset_vga_char", vga_char, 0);
      chk("reset_strobe", vga_strobe, 0);
      chk("reset_cipher_idx", cipher_idx, 0);

      // Key "BC", encrypt, decrypt, back to idle
      do_enter();
      do_key("b"); do_key("c");
      do_enter();
      do_key("a"); do_key("a"); do_key("Z"); do_key("!"); do_key("y");
      do_enter();
      do_key("b"); do_key("c"); do_key("A");
      do_enter();

      // Empty key is refused, overlong key truncated
      do_enter();
      do_enter();
      do_key("A"); do_key("B"); do_key("C"); do_key("D"); do_key("E");
      chk("full_key_idx", cipher_idx, KS - 1);
      do_enter();
      do_key("h"); do_key("i");
      do_both("x");
      do_key("q");
      do_enter();

      // Reset while a keystroke is being taken
      do_enter(); do_key("k");
      do_reset_key("m");

      for (int i = 0; i < 400; i++) begin
         r = $urandom_range(0, 99);
         if (r < 8) do_enter();
         else if (r < 11 && m_state != 1) do_both(rand_char());
         else if (r < 12) do_reset_key(rand_char());
         else do_key(rand_char());
      end

      repeat (3) @(negedge clk);
      #1;
      chk("final_queue_empty", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
